// File: rtl/lifo_stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lifo_stack_ctrl_pkg
// Shared definitions for the LIFO stack controller: command encodings, the
// default geometry and the fixed 3-bit count type.
// No ports (package).
// -----------------------------------------------------------------------------
package lifo_stack_ctrl_pkg;

    localparam int LIFO_WIDTH_DEF = 4;
    localparam int LIFO_DEPTH_DEF = 4;

    // Command field W; the remaining codes (2'b10, 2'b11) are no-ops.
    localparam logic [1:0] CMD_PUSH = 2'b00;
    localparam logic [1:0] CMD_POP  = 2'b01;

    // The stack count is always carried in 3 bits regardless of DEPTH.
    typedef logic [2:0] count_t;

endpackage

// File: rtl/lifo_stack_ctrl_next_count.sv
// -----------------------------------------------------------------------------
// stack_next_count
// Purely combinational next-count logic for the LIFO stack controller.
// Ports:
//   y      in  3  current registered count
//   w      in  2  command (push / pop / no-op)
//   go     in  1  command strobe
//   next_y out 3  count to be registered on the next edge
// -----------------------------------------------------------------------------
module stack_next_count
    import lifo_stack_ctrl_pkg::*;
#(
    parameter int DEPTH = LIFO_DEPTH_DEF
) (
    input  logic [2:0] y,
    input  logic [1:0] w,
    input  logic       go,
    output logic [2:0] next_y
);

    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    always_comb begin
        next_y = y;
        // Codes above DEPTH cannot be reached in normal operation; if one
        // ever appears, recover to an empty stack.
        if (y > DEPTH_C) begin
            next_y = 3'd0;
        end else if (go && (w == CMD_PUSH) && (y < DEPTH_C)) begin
            next_y = y + 3'd1;
        end else if (go && (w == CMD_POP) && (y != 3'd0)) begin
            next_y = y - 3'd1;
        end
    end

endmodule

// File: rtl/lifo_stack_ctrl.sv
// -----------------------------------------------------------------------------
// lifo_stack_ctrl
// Small LIFO stack with a registered count and a registered top-of-stack
// value. Commands are accepted only when Go is high; illegal pushes/pops
// leave the stack untouched and raise a one-cycle error pulse.
// Ports:
//   Clock     in  1      single clock, rising edge
//   Reset     in  1      synchronous active-high reset
//   Go        in  1      command strobe
//   W         in  2      command: 00 push, 01 pop, 1x no-op
//   Din       in  WIDTH  data written on push
//   Y         out 3      registered entry count 0..DEPTH
//   Top       out WIDTH  registered top entry, 0 when empty
//   Full      out 1      Y == DEPTH
//   Empty     out 1      Y == 0
//   Overflow  out 1      one-cycle pulse after a push while full
//   Underflow out 1      one-cycle pulse after a pop while empty
// -----------------------------------------------------------------------------
module lifo_stack_ctrl
    import lifo_stack_ctrl_pkg::*;
#(
    parameter int WIDTH = LIFO_WIDTH_DEF,
    parameter int DEPTH = LIFO_DEPTH_DEF
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Go,
    input  logic [1:0]       W,
    input  logic [WIDTH-1:0] Din,
    output logic [2:0]       Y,
    output logic [WIDTH-1:0] Top,
    output logic             Full,
    output logic             Empty,
    output logic             Overflow,
    output logic             Underflow
);

    localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    count_t           next_y;
    logic             do_push;
    logic             do_pop;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    below_idx;

    stack_next_count #(
        .DEPTH (DEPTH)
    ) u_next_count (
        .y      (Y),
        .w      (W),
        .go     (Go),
        .next_y (next_y)
    );

    assign Full  = (Y == DEPTH_C);
    assign Empty = (Y == 3'd0);

    assign do_push = Go && (W == CMD_PUSH) && (Y < DEPTH_C);
    assign do_pop  = Go && (W == CMD_POP) && (Y != 3'd0) && (Y <= DEPTH_C);

    // Push writes slot Y; after a pop the new top is the entry just below
    // the one being removed, i.e. slot Y-2 (only meaningful when Y >= 2).
    assign wr_idx    = AW'(Y);
    assign below_idx = AW'(Y - 3'd2);

    // Storage is never reset; popped slots keep stale data that is simply
    // no longer reachable through Top.
    always_ff @(posedge Clock) begin
        if (!Reset && do_push) begin
            mem[wr_idx] <= Din;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Y         <= 3'd0;
            Top       <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Y         <= next_y;
            Overflow  <= Go && (W == CMD_PUSH) && (Y == DEPTH_C);
            Underflow <= Go && (W == CMD_POP) && (Y == 3'd0);
            if (Y > DEPTH_C) begin
                Top <= '0;
            end else if (do_push) begin
                Top <= Din;
            end else if (do_pop) begin
                Top <= (Y == 3'd1) ? '0 : mem[below_idx];
            end
        end
    end

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack_ctrl
// Self-checking bench for lifo_stack_ctrl: directed scenarios followed by
// random commands, all compared against a queue-based stack model.
// -----------------------------------------------------------------------------
module tb_lifo_stack_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             Clock;
    logic             Reset;
    logic             Go;
    logic [1:0]       W;
    logic [WIDTH-1:0] Din;
    logic [2:0]       Y;
    logic [WIDTH-1:0] Top;
    logic             Full;
    logic             Empty;
    logic             Overflow;
    logic             Underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: the stack contents as a queue, newest at the back.
    int stk[$];
    bit m_ovf;
    bit m_unf;

    lifo_stack_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Go        (Go),
        .W         (W),
        .Din       (Din),
        .Y         (Y),
        .Top       (Top),
        .Full      (Full),
        .Empty     (Empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit go, input bit [1:0] w,
                              input int din);
        m_ovf = 1'b0;
        m_unf = 1'b0;
        if (rst) begin
            stk.delete();
        end else if (go && w == 2'b00) begin
            if (stk.size() < DEPTH) stk.push_back(din);
            else m_ovf = 1'b1;
        end else if (go && w == 2'b01) begin
            if (stk.size() > 0) void'(stk.pop_back());
            else m_unf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        int exp_top;
        exp_top = (stk.size() == 0) ? 0 : stk[$];
        chk({tag, ".Y"}, int'(Y), stk.size());
        chk({tag, ".Top"}, int'(Top), exp_top);
        chk({tag, ".Full"}, int'(Full), int'(stk.size() == DEPTH));
        chk({tag, ".Empty"}, int'(Empty), int'(stk.size() == 0));
        chk({tag, ".Overflow"}, int'(Overflow), int'(m_ovf));
        chk({tag, ".Underflow"}, int'(Underflow), int'(m_unf));
    endtask

    // Apply one cycle of inputs, let the edge happen, then compare 1 ns later.
    task automatic step(input string tag, input bit rst, input bit go,
                        input bit [1:0] w, input int din);
        Reset = rst;
        Go    = go;
        W     = w;
        Din   = WIDTH'(din);
        @(posedge Clock);
        #1;
        model_step(rst, go, w, din);
        check_all(tag);
    endtask

    initial begin
        Reset = 1'b1;
        Go    = 1'b0;
        W     = 2'b11;
        Din   = '0;
        @(negedge Clock);

        // Reset state
        step("reset", 1, 0, 2'b00, 0);

        // Consecutive pushes 3, 5, 9
        step("push3", 0, 1, 2'b00, 3);
        step("push5", 0, 1, 2'b00, 5);
        step("push9", 0, 1, 2'b00, 9);

        // Fill, then overflow and observe the pulse clearing
        step("push7", 0, 1, 2'b00, 7);
        step("push2_ovf", 0, 1, 2'b00, 2);
        step("after_ovf", 0, 0, 2'b11, 0);

        // Drain completely, then underflow
        step("pop1", 0, 1, 2'b01, 0);
        step("pop2", 0, 1, 2'b01, 0);
        step("pop3", 0, 1, 2'b01, 0);
        step("pop4", 0, 1, 2'b01, 0);
        step("pop5_unf", 0, 1, 2'b01, 0);
        step("after_unf", 0, 0, 2'b00, 0);

        // Holds: Go low with a push pending, then no-op command codes
        step("push1", 0, 1, 2'b00, 1);
        step("hold_a", 0, 0, 2'b00, 15);
        step("hold_b", 0, 0, 2'b00, 15);
        step("hold_c", 0, 0, 2'b00, 15);
        step("noop10", 0, 1, 2'b10, 15);
        step("noop11", 0, 1, 2'b11, 15);

        // Reset wins over a simultaneous push
        step("push4", 0, 1, 2'b00, 4);
        step("rst_push", 1, 1, 2'b00, 6);
        step("push6", 0, 1, 2'b00, 6);

        // Pop back over stale storage: Top must follow the live stack
        step("push8", 0, 1, 2'b00, 8);
        step("pop_s1", 0, 1, 2'b01, 0);
        step("pop_s2", 0, 1, 2'b01, 0);
        step("push10", 0, 1, 2'b00, 10);

        // Random traffic, biased toward push/pop with occasional resets
        for (int i = 0; i < 400; i++) begin
            bit       r_rst;
            bit       r_go;
            bit [1:0] r_w;
            int       r_din;
            r_rst = ($urandom_range(0, 39) == 0);
            r_go  = ($urandom_range(0, 4) != 0);
            r_w   = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3))
                                                : 2'($urandom_range(0, 1));
            r_din = $urandom_range(0, 15);
            step("rand", r_rst, r_go, r_w, r_din);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lifo_stack_ctrl.md
LIFO_STACK_CTRL -- requirements
Module: lifo_stack_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data bits per stack entry.
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; the count encoding is 3 bits.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Go, input, 1, command strobe; W is acted on only in a cycle with Go=1.
REQ-006 SHALL have port W, input, 2, command: 00 push, 01 pop, 10/11 no-op.
REQ-007 SHALL have port Din, input, WIDTH, data written on push.
REQ-008 SHALL have port Y, output, 3, registered stack count 0..DEPTH.
REQ-009 SHALL have port Top, output, WIDTH, registered value of the top entry; 0 when empty.
REQ-010 SHALL have ports Full and Empty, output, 1 each, combinational decode of Y (Y==DEPTH, Y==0).
REQ-011 SHALL have ports Overflow and Underflow, output, 1 each, registered one-cycle error pulses.

Function
REQ-012 SHALL compute the next count combinationally from (Y, W, Go) and register it each edge.
REQ-013 SHALL, on Go=1 and W=00 with Y<DEPTH, write Din to entry Y, increment Y, and set Top=Din at the same edge.
REQ-014 SHALL, on Go=1 and W=01 with Y>0, decrement Y and set Top to entry Y-2 at the same edge, or 0 if the new Y is 0.
REQ-015 SHALL, on Go=0 or W=1x, hold Y, Top and all entries.
REQ-016 SHALL, on a push while Y==DEPTH, leave Y, Top and entries unchanged and assert Overflow for exactly the next cycle.
REQ-017 SHALL, on a pop while Y==0, leave Y at 0 and Top at 0, and assert Underflow for exactly the next cycle.
REQ-018 SHALL deassert Overflow and Underflow in every cycle not caused by REQ-016 or REQ-017.
REQ-019 SHALL have a latency of one clock from a sampled Go to updated Y and Top; back-to-back Go cycles are each honoured.
REQ-020 SHALL never drive Y outside 0..DEPTH; unreachable codes 5..7 SHALL force the next Y to 0.
REQ-021 SHALL leave popped entries' storage stale; those entries SHALL NOT be visible on Top.

Reset
REQ-022 SHALL, with Reset=1 at an edge, set Y=0, Top=0, Overflow=0 and Underflow=0, regardless of Go and W.
REQ-023 SHALL let Reset take priority over a simultaneous command; the command is discarded.
REQ-024 SHALL NOT require storage entries to be cleared by reset.

Structure
REQ-025 SHALL take the command encodings (PUSH=2'b00, POP=2'b01) and the DEPTH/WIDTH defaults from a shared package or include.
REQ-026 SHALL place the next-count logic in one combinational sub-module, stack_next_count, with inputs (y, w, go) and output next_y.
REQ-027 SHALL keep storage, the Top register and the error-pulse registers in lifo_stack_ctrl.

Verification
REQ-028 Reset, then push 3,5,9 on consecutive cycles -> Y=1,2,3 and Top=3,5,9 one cycle after each; Empty=0.
REQ-029 From Y=3, push 7 then push 2 -> Y=4 with Full=1 and Top=7; Overflow=1 for one cycle, then Y=4, Top=7.
REQ-030 From full (3,5,9,7), pop ×4 -> Top=9,5,3,0 and Y=3,2,1,0; a fifth pop -> Underflow=1 for one cycle, Y=0.
REQ-031 Go=0 with W=00 and Din=F for 3 cycles -> Y and Top unchanged; then W=10 with Go=1 -> unchanged.
REQ-032 At Y=2, assert Reset in the same cycle as a push of 6 -> Y=0, Top=0, all pulses 0; a following push of 6 -> Y=1, Top=6.
